// File: rtl/fib_arbiter.sv
// -----------------------------------------------------------------------------
// fib_arbiter
//
// Shares a single Fibonacci core among NUM_PORTS requesters. Each requester has
// a valid/ready request channel carrying a signed 32-bit n and a one-deep
// buffered valid/ready response channel carrying the signed 64-bit result.
// One computation is in flight at a time. Ports are served round-robin,
// starting the scan one past the most recently granted port. A port whose
// previous response has not been taken yet is skipped, so a stalled consumer
// cannot hold up the other ports.
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-high reset
//   s_req_valid   per-port request valid
//   s_req_ready   per-port request accept (one-hot or zero, only in IDLE)
//   s_req_n       per-port signed n, port p at [32p+31:32p]
//   s_rsp_valid   per-port result valid (registered)
//   s_rsp_ready   per-port result accept
//   s_rsp_return  per-port signed result, port p at [64p+63:64p]
//   fib_n         argument to the core (always the latched request)
//   fib_req       one-cycle start pulse to the core
//   fib_busy      core busy; high after the core's own reset until it is idle
//   fib_return    core result, valid once fib_busy falls
//   grant         index of the port owning the core, 0 when idle
// -----------------------------------------------------------------------------
module fib_arbiter #(
  parameter int NUM_PORTS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_PORTS-1:0]      s_req_valid,
  output logic [NUM_PORTS-1:0]      s_req_ready,
  input  logic [NUM_PORTS*32-1:0]   s_req_n,
  output logic [NUM_PORTS-1:0]      s_rsp_valid,
  input  logic [NUM_PORTS-1:0]      s_rsp_ready,
  output logic [NUM_PORTS*64-1:0]   s_rsp_return,
  output logic signed [31:0]        fib_n,
  output logic                      fib_req,
  input  logic                      fib_busy,
  input  logic signed [63:0]        fib_return,
  output logic [3:0]                grant
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_START,
    WAIT_DONE
  } state_t;

  state_t             state;
  state_t             state_nxt;

  logic signed [31:0] n_reg;
  logic [3:0]         last_grant;
  logic [63:0]        rsp_data [NUM_PORTS];

  logic [NUM_PORTS-1:0] eligible;
  logic                 pick_found;
  logic [3:0]           pick_idx;
  logic signed [31:0]   pick_n;
  int                   pick_dist;
  int                   pick_best;

  logic                 accept;
  logic                 done;

  // A port with an unread response is not eligible. Using the registered
  // s_rsp_valid here means a slot being drained this cycle is never re-granted
  // in the same cycle.
  assign eligible = s_req_valid & ~s_rsp_valid;

  // ---------------------------------------------------------------------------
  // Round-robin pick. Each eligible port gets a distance from the start of the
  // scan (last_grant + 1, wrapping); the smallest distance wins. Working with
  // distances keeps every array and vector index a loop constant.
  // ---------------------------------------------------------------------------
  // NOTE: every variable written in an always_comb gets a default before any
  // conditional assignment; a path that leaves one unassigned infers a latch.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_best  = NUM_PORTS;
    pick_dist  = 0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      pick_dist = p + NUM_PORTS - 1 - int'(last_grant);
      if (pick_dist >= NUM_PORTS) begin
        pick_dist = pick_dist - NUM_PORTS;
      end
      if (eligible[p] && (pick_dist < pick_best)) begin
        pick_best  = pick_dist;
        pick_found = 1'b1;
        pick_idx   = 4'(p);
      end
    end
  end

  // Argument of the winning port.
  always_comb begin
    pick_n = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (pick_idx == 4'(p)) begin
        pick_n = s_req_n[32*p +: 32];
      end
    end
  end

  // A new job only starts when the core reports idle; this also keeps the
  // arbiter parked after reset until the core has finished its own reset.
  assign accept = (state == IDLE) && !fib_busy && pick_found;
  assign done   = (state == WAIT_DONE) && !fib_busy;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (accept)    state_nxt = ISSUE;
      ISSUE:                     state_nxt = WAIT_START;
      // The core raises busy the cycle after the start pulse; wait for it so
      // the done check cannot see the pre-start idle level.
      WAIT_START: if (fib_busy)  state_nxt = WAIT_DONE;
      WAIT_DONE:  if (!fib_busy) state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  assign fib_req = (state == ISSUE);
  assign fib_n   = n_reg;

  always_comb begin
    s_req_ready = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      s_req_ready[p] = accept && (pick_idx == 4'(p));
    end
  end

  // ---------------------------------------------------------------------------
  // Request latch, grant bookkeeping and response slots
  // ---------------------------------------------------------------------------
  // NOTE: the response slots are an array but are still reset, because their
  // contents are visible on s_rsp_return and must read zero out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_reg       <= '0;
      grant       <= '0;
      last_grant  <= 4'(NUM_PORTS - 1);
      s_rsp_valid <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        rsp_data[p] <= '0;
      end
    end else begin
      if (accept) begin
        n_reg      <= pick_n;
        grant      <= pick_idx;
        last_grant <= pick_idx;
      end
      if (done) begin
        grant <= '0;
      end
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (s_rsp_valid[p] && s_rsp_ready[p]) begin
          s_rsp_valid[p] <= 1'b0;
        end
        // The owner had no pending response when granted, so a completion
        // never collides with a drain on the same slot.
        if (done && (grant == 4'(p))) begin
          s_rsp_valid[p] <= 1'b1;
          rsp_data[p]    <= fib_return;
        end
      end
    end
  end

  for (genvar gp = 0; gp < NUM_PORTS; gp++) begin : g_rsp_out
    assign s_rsp_return[64*gp +: 64] = rsp_data[gp];
  end

endmodule
